// File: rtl/sy_axi4_sram_slave_if.sv
// AXI4 channel types and the slave-side bus interface for sy_axi4_sram_slave.
package axi_pkg;
  localparam int AXI_ID_W   = 4;
  localparam int AXI_ADDR_W = 32;
  localparam int AXI_DATA_W = 64;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;
  localparam logic [1:0] BURST_RSVD  = 2'b11;

  typedef struct packed {
    logic [AXI_ID_W-1:0]   id;
    logic [AXI_ADDR_W-1:0] addr;
    logic [7:0]            len;
    logic [2:0]            size;
    logic [1:0]            burst;
  } aw_chan_t;

  typedef struct packed {
    logic [AXI_ID_W-1:0]   id;
    logic [AXI_ADDR_W-1:0] addr;
    logic [7:0]            len;
    logic [2:0]            size;
    logic [1:0]            burst;
  } ar_chan_t;

  typedef struct packed {
    logic [AXI_DATA_W-1:0]   data;
    logic [AXI_DATA_W/8-1:0] strb;
    logic                    last;
  } w_chan_t;

  typedef struct packed {
    logic [AXI_ID_W-1:0]   id;
    logic [AXI_DATA_W-1:0] data;
    logic [1:0]            resp;
    logic                  last;
  } r_chan_t;

  typedef struct packed {
    logic [AXI_ID_W-1:0] id;
    logic [1:0]          resp;
  } b_chan_t;
endpackage

interface sy_axi4_sram_slave_if;
  import axi_pkg::*;
  logic     aw_valid, aw_ready;
  aw_chan_t aw_bits;
  logic     ar_valid, ar_ready;
  ar_chan_t ar_bits;
  logic     w_valid, w_ready;
  w_chan_t  w_bits;
  logic     r_valid, r_ready;
  r_chan_t  r_bits;
  logic     b_valid, b_ready;
  b_chan_t  b_bits;

  modport master (
    output aw_valid, aw_bits, ar_valid, ar_bits, w_valid, w_bits, r_ready, b_ready,
    input  aw_ready, ar_ready, w_ready, r_valid, r_bits, b_valid, b_bits
  );
  modport slave (
    input  aw_valid, aw_bits, ar_valid, ar_bits, w_valid, w_bits, r_ready, b_ready,
    output aw_ready, ar_ready, w_ready, r_valid, r_bits, b_valid, b_bits
  );
endinterface

// File: rtl/sy_axi4_sram_slave.sv
// sy_axi4_sram_slave: one-transaction-at-a-time AXI4 responder onto a
// single-port synchronous SRAM (1-cycle read latency). FIXED/INCR/WRAP bursts,
// out-of-range beats answered with DECERR and never reach the SRAM.
module sy_axi4_sram_slave
  import axi_pkg::*;
#(
  parameter int                    DATA_W    = 64,
  parameter int                    MEM_BYTES = 65536,
  parameter logic [AXI_ADDR_W-1:0] BASE_ADDR = '0,
  localparam int                   OFF_W     = $clog2(DATA_W/8),
  localparam int                   MA_W      = $clog2(MEM_BYTES/(DATA_W/8))
) (
  input  logic                clk_i,
  input  logic                rst_i,
  sy_axi4_sram_slave_if.slave slv_axi,
  output logic                mem_req_o,
  output logic                mem_we_o,
  output logic [MA_W-1:0]     mem_addr_o,
  output logic [DATA_W-1:0]   mem_wdata_o,
  output logic [DATA_W/8-1:0] mem_be_o,
  input  logic [DATA_W-1:0]   mem_rdata_i
);

  typedef enum logic [2:0] {IDLE, R_ISSUE, R_DATA, W_DATA, B_RESP} state_e;

  localparam logic [AXI_ADDR_W:0] MEM_LIM = (AXI_ADDR_W+1)'(MEM_BYTES);

  state_e                state_q, state_d;
  logic                  rd_first_q, rd_first_d;
  logic [AXI_ID_W-1:0]   id_q, id_d;
  logic [AXI_ADDR_W-1:0] addr_q, addr_d;
  logic [7:0]            len_q, len_d;
  logic [2:0]            size_q, size_d;
  logic [1:0]            burst_q, burst_d;
  logic [7:0]            cnt_q, cnt_d;
  logic [1:0]            resp_q, resp_d;
  logic [DATA_W-1:0]     rdata_q, rdata_d;
  // high for the first R_DATA cycle, when the SRAM output is live
  logic                  fresh_q, fresh_d;

  logic [AXI_ADDR_W-1:0] off, step, wmask, addr_nxt;
  logic                  in_range, last_beat;

  // BASE_ADDR is aligned to MEM_BYTES, so a wrapped offset below MEM_BYTES is in range
  assign off         = addr_q - BASE_ADDR;
  assign in_range    = ({1'b0, off} < MEM_LIM);
  assign last_beat   = (cnt_q == 8'd0);
  assign mem_addr_o  = off[OFF_W +: MA_W];
  assign mem_wdata_o = slv_axi.w_bits.data;

  // next beat address for the latched burst type
  always_comb begin
    step  = AXI_ADDR_W'(1) << size_q;
    wmask = ((AXI_ADDR_W'(len_q) + AXI_ADDR_W'(1)) << size_q) - AXI_ADDR_W'(1);
    case (burst_q)
      BURST_FIXED: addr_nxt = addr_q;
      BURST_WRAP:  addr_nxt = (addr_q & ~wmask) | ((addr_q + step) & wmask);
      default:     addr_nxt = addr_q + step;  // INCR and reserved
    endcase
  end

  // FSM next state, channel handshakes and SRAM strobes
  always_comb begin
    state_d    = state_q;
    rd_first_d = rd_first_q;
    id_d       = id_q;
    addr_d     = addr_q;
    len_d      = len_q;
    size_d     = size_q;
    burst_d    = burst_q;
    cnt_d      = cnt_q;
    resp_d     = resp_q;
    rdata_d    = rdata_q;
    fresh_d    = 1'b0;
    slv_axi.ar_ready = 1'b0;
    slv_axi.aw_ready = 1'b0;
    slv_axi.w_ready  = 1'b0;
    slv_axi.r_valid  = 1'b0;
    slv_axi.r_bits   = '0;
    slv_axi.b_valid  = 1'b0;
    slv_axi.b_bits   = '0;
    mem_req_o  = 1'b0;
    mem_we_o   = 1'b0;
    mem_be_o   = '0;
    case (state_q)
      IDLE: begin
        slv_axi.ar_ready = slv_axi.ar_valid & (~slv_axi.aw_valid | rd_first_q);
        slv_axi.aw_ready = slv_axi.aw_valid & (~slv_axi.ar_valid | ~rd_first_q);
        if (slv_axi.ar_ready) begin
          id_d       = slv_axi.ar_bits.id;
          addr_d     = slv_axi.ar_bits.addr;
          len_d      = slv_axi.ar_bits.len;
          size_d     = slv_axi.ar_bits.size;
          burst_d    = slv_axi.ar_bits.burst;
          cnt_d      = slv_axi.ar_bits.len;
          resp_d     = RESP_OKAY;
          rd_first_d = ~rd_first_q;
          state_d    = R_ISSUE;
        end else if (slv_axi.aw_ready) begin
          id_d       = slv_axi.aw_bits.id;
          addr_d     = slv_axi.aw_bits.addr;
          len_d      = slv_axi.aw_bits.len;
          size_d     = slv_axi.aw_bits.size;
          burst_d    = slv_axi.aw_bits.burst;
          cnt_d      = slv_axi.aw_bits.len;
          resp_d     = (slv_axi.aw_bits.burst == BURST_RSVD) ? RESP_SLVERR : RESP_OKAY;
          rd_first_d = ~rd_first_q;
          state_d    = W_DATA;
        end
      end
      R_ISSUE: begin
        mem_req_o = in_range;
        fresh_d   = 1'b1;
        state_d   = R_DATA;
      end
      R_DATA: begin
        slv_axi.r_valid     = 1'b1;
        slv_axi.r_bits.id   = id_q;
        slv_axi.r_bits.last = last_beat;
        if (!in_range) begin
          slv_axi.r_bits.resp = RESP_DECERR;
        end else begin
          slv_axi.r_bits.data = fresh_q ? mem_rdata_i : rdata_q;
          slv_axi.r_bits.resp = (burst_q == BURST_RSVD) ? RESP_SLVERR : RESP_OKAY;
        end
        rdata_d = slv_axi.r_bits.data;
        if (slv_axi.r_ready) begin
          if (last_beat) begin
            state_d = IDLE;
          end else begin
            cnt_d   = cnt_q - 8'd1;
            addr_d  = addr_nxt;
            state_d = R_ISSUE;
          end
        end
      end
      W_DATA: begin
        slv_axi.w_ready = 1'b1;
        if (slv_axi.w_valid) begin
          mem_req_o = in_range;
          mem_we_o  = in_range;
          mem_be_o  = slv_axi.w_bits.strb;
          if (!in_range)
            resp_d = RESP_DECERR;
          else if ((slv_axi.w_bits.last != last_beat) && (resp_q != RESP_DECERR))
            resp_d = RESP_SLVERR;
          cnt_d  = cnt_q - 8'd1;
          addr_d = addr_nxt;
          if (last_beat) state_d = B_RESP;
        end
      end
      B_RESP: begin
        slv_axi.b_valid     = 1'b1;
        slv_axi.b_bits.id   = id_q;
        slv_axi.b_bits.resp = resp_q;
        if (slv_axi.b_ready) begin
          resp_d  = RESP_OKAY;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // state and transaction registers
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q    <= IDLE;
      rd_first_q <= 1'b1;
      id_q       <= '0;
      addr_q     <= '0;
      len_q      <= '0;
      size_q     <= '0;
      burst_q    <= '0;
      cnt_q      <= '0;
      resp_q     <= '0;
      rdata_q    <= '0;
      fresh_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      rd_first_q <= rd_first_d;
      id_q       <= id_d;
      addr_q     <= addr_d;
      len_q      <= len_d;
      size_q     <= size_d;
      burst_q    <= burst_d;
      cnt_q      <= cnt_d;
      resp_q     <= resp_d;
      rdata_q    <= rdata_d;
      fresh_q    <= fresh_d;
    end
  end

endmodule

// File: tb/tb_sy_axi4_sram_slave.sv
// Scoreboard bench for sy_axi4_sram_slave: stimulus pushes expected SRAM
// accesses, R beats and B responses; a negedge monitor pops and compares.
module tb_sy_axi4_sram_slave;
  import axi_pkg::*;

  logic clk_i = 1'b0;
  logic rst_i = 1'b0;
  always #5 clk_i = ~clk_i;

  sy_axi4_sram_slave_if axi();

  logic        mem_req, mem_we;
  logic [12:0] mem_addr;
  logic [63:0] mem_wdata, mem_rdata;
  logic [7:0]  mem_be;

  sy_axi4_sram_slave #(.DATA_W(64), .MEM_BYTES(65536), .BASE_ADDR(32'h0)) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .slv_axi     (axi),
    .mem_req_o   (mem_req),
    .mem_we_o    (mem_we),
    .mem_addr_o  (mem_addr),
    .mem_wdata_o (mem_wdata),
    .mem_be_o    (mem_be),
    .mem_rdata_i (mem_rdata)
  );

  // behavioural SRAM, 1-cycle read latency
  logic [63:0] mem [0:8191];
  always @(posedge clk_i) begin
    if (mem_req) begin
      if (mem_we) begin
        for (int b = 0; b < 8; b++)
          if (mem_be[b]) mem[mem_addr][b*8 +: 8] = mem_wdata[b*8 +: 8];
      end else begin
        mem_rdata <= mem[mem_addr];
      end
    end
  end

  typedef struct {
    logic        we;
    logic [12:0] addr;
    logic [63:0] data;
    logic [7:0]  be;
  } mexp_t;

  mexp_t   mq[$];
  r_chan_t rq[$];
  b_chan_t bq[$];
  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  task automatic timeout(string nm);
    n_chk++;
    n_fail++;
    $display("FAIL %s: timed out, expected a handshake", nm);
  endtask

  task automatic exp_rd(int a);
    mexp_t e;
    e.we = 1'b0; e.addr = 13'(a); e.data = '0; e.be = '0;
    mq.push_back(e);
  endtask

  task automatic exp_wr(int a, logic [63:0] d, logic [7:0] be);
    mexp_t e;
    e.we = 1'b1; e.addr = 13'(a); e.data = d; e.be = be;
    mq.push_back(e);
  endtask

  task automatic exp_r(logic [3:0] i, logic [63:0] d, logic [1:0] rs, logic l);
    r_chan_t r;
    r.id = i; r.data = d; r.resp = rs; r.last = l;
    rq.push_back(r);
  endtask

  task automatic exp_b(logic [3:0] i, logic [1:0] rs);
    b_chan_t b;
    b.id = i; b.resp = rs;
    bq.push_back(b);
  endtask

  // monitor: every SRAM strobe and R/B handshake must match the queue head
  always @(negedge clk_i) begin
    if (rst_i) begin
      if (mem_req) begin
        if (mq.size() == 0) begin
          n_chk++; n_fail++;
          $display("FAIL mem_unexpected: got access we=%b addr=%h, expected none", mem_we, mem_addr);
        end else begin
          mexp_t e;
          e = mq.pop_front();
          chk("mem_we", 64'(mem_we), 64'(e.we));
          chk("mem_addr", 64'(mem_addr), 64'(e.addr));
          if (e.we) begin
            chk("mem_wdata", mem_wdata, e.data);
            chk("mem_be", 64'(mem_be), 64'(e.be));
          end
        end
      end
      if (axi.r_valid && axi.r_ready) begin
        if (rq.size() == 0) begin
          n_chk++; n_fail++;
          $display("FAIL r_unexpected: got beat data=%h, expected none", axi.r_bits.data);
        end else begin
          r_chan_t r;
          r = rq.pop_front();
          chk("r_id", 64'(axi.r_bits.id), 64'(r.id));
          chk("r_data", axi.r_bits.data, r.data);
          chk("r_resp", 64'(axi.r_bits.resp), 64'(r.resp));
          chk("r_last", 64'(axi.r_bits.last), 64'(r.last));
        end
      end
      if (axi.b_valid && axi.b_ready) begin
        if (bq.size() == 0) begin
          n_chk++; n_fail++;
          $display("FAIL b_unexpected: got resp=%h, expected none", axi.b_bits.resp);
        end else begin
          b_chan_t b;
          b = bq.pop_front();
          chk("b_id", 64'(axi.b_bits.id), 64'(b.id));
          chk("b_resp", 64'(axi.b_bits.resp), 64'(b.resp));
        end
      end
    end
  end

  // all drivers below are entered just after a posedge
  task automatic send_ar(logic [3:0] i, logic [31:0] a, logic [7:0] l, logic [2:0] s, logic [1:0] bt);
    bit ok = 1'b0;
    axi.ar_bits.id = i; axi.ar_bits.addr = a; axi.ar_bits.len = l;
    axi.ar_bits.size = s; axi.ar_bits.burst = bt;
    axi.ar_valid = 1'b1;
    for (int k = 0; k < 100 && !ok; k++) begin
      @(negedge clk_i); ok = axi.ar_ready;
      @(posedge clk_i); #1;
    end
    axi.ar_valid = 1'b0;
    if (!ok) timeout("ar_accept");
  endtask

  task automatic send_aw(logic [3:0] i, logic [31:0] a, logic [7:0] l, logic [2:0] s, logic [1:0] bt);
    bit ok = 1'b0;
    axi.aw_bits.id = i; axi.aw_bits.addr = a; axi.aw_bits.len = l;
    axi.aw_bits.size = s; axi.aw_bits.burst = bt;
    axi.aw_valid = 1'b1;
    for (int k = 0; k < 100 && !ok; k++) begin
      @(negedge clk_i); ok = axi.aw_ready;
      @(posedge clk_i); #1;
    end
    axi.aw_valid = 1'b0;
    if (!ok) timeout("aw_accept");
  endtask

  task automatic send_w(logic [63:0] d, logic [7:0] st, logic l);
    bit ok = 1'b0;
    axi.w_bits.data = d; axi.w_bits.strb = st; axi.w_bits.last = l;
    axi.w_valid = 1'b1;
    for (int k = 0; k < 100 && !ok; k++) begin
      @(negedge clk_i); ok = axi.w_ready;
      @(posedge clk_i); #1;
    end
    axi.w_valid = 1'b0;
    if (!ok) timeout("w_accept");
  endtask

  task automatic drain(string nm);
    int n = 0;
    while ((mq.size() + rq.size() + bq.size()) != 0 && n < 300) begin
      @(posedge clk_i); n++;
    end
    n_chk++;
    if (n >= 300) begin
      n_fail++;
      $display("FAIL drain_%s: %0d items left, expected 0", nm, mq.size() + rq.size() + bq.size());
    end
    repeat (3) @(posedge clk_i);
    #1;
  endtask

  task automatic chk_idle_outputs(string nm);
    chk({nm, "_ar_ready"}, 64'(axi.ar_ready), 64'd0);
    chk({nm, "_aw_ready"}, 64'(axi.aw_ready), 64'd0);
    chk({nm, "_w_ready"},  64'(axi.w_ready),  64'd0);
    chk({nm, "_r_valid"},  64'(axi.r_valid),  64'd0);
    chk({nm, "_b_valid"},  64'(axi.b_valid),  64'd0);
    chk({nm, "_mem_req"},  64'(mem_req),      64'd0);
    chk({nm, "_mem_we"},   64'(mem_we),       64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    axi.ar_valid = 0; axi.ar_bits = '0;
    axi.aw_valid = 0; axi.aw_bits = '0;
    axi.w_valid  = 0; axi.w_bits  = '0;
    axi.r_ready  = 1; axi.b_ready = 1;
    mem[16] = 64'hDEADBEEF_01234567;

    // reset state
    repeat (3) @(posedge clk_i);
    #1;
    chk_idle_outputs("reset");
    rst_i = 1'b1;
    @(posedge clk_i); #1;

    // single read of word 0x10
    exp_rd(16);
    exp_r(4'd5, 64'hDEADBEEF_01234567, RESP_OKAY, 1'b1);
    send_ar(4'd5, 32'h80, 8'd0, 3'd3, BURST_INCR);
    drain("single_read");

    // INCR write then readback
    for (int k = 0; k < 4; k++) exp_wr(32 + k, 64'(k + 1), 8'hFF);
    exp_b(4'd2, RESP_OKAY);
    send_aw(4'd2, 32'h100, 8'd3, 3'd3, BURST_INCR);
    for (int k = 0; k < 4; k++) send_w(64'(k + 1), 8'hFF, k == 3);
    drain("incr_write");
    for (int k = 0; k < 4; k++) begin
      exp_rd(32 + k);
      exp_r(4'd3, 64'(k + 1), RESP_OKAY, k == 3);
    end
    send_ar(4'd3, 32'h100, 8'd3, 3'd3, BURST_INCR);
    drain("incr_read");

    // WRAP read starting mid-window
    exp_rd(35); exp_r(4'd9, 64'd4, RESP_OKAY, 1'b0);
    exp_rd(32); exp_r(4'd9, 64'd1, RESP_OKAY, 1'b0);
    exp_rd(33); exp_r(4'd9, 64'd2, RESP_OKAY, 1'b0);
    exp_rd(34); exp_r(4'd9, 64'd3, RESP_OKAY, 1'b1);
    send_ar(4'd9, 32'h118, 8'd3, 3'd3, BURST_WRAP);
    drain("wrap_read");

    // simultaneous AR/AW after reset with R/B backpressure
    rst_i = 1'b0;
    repeat (2) @(posedge clk_i);
    #1;
    rst_i = 1'b1;
    axi.r_ready = 1'b0;
    axi.b_ready = 1'b0;
    exp_rd(16);
    exp_wr(64, 64'hAA, 8'hFF);
    exp_r(4'd1, 64'hDEADBEEF_01234567, RESP_OKAY, 1'b1);
    exp_b(4'd2, RESP_OKAY);
    fork
      send_ar(4'd1, 32'h80, 8'd0, 3'd3, BURST_INCR);
      begin
        send_aw(4'd2, 32'h200, 8'd0, 3'd3, BURST_INCR);
        send_w(64'hAA, 8'hFF, 1'b1);
      end
      begin
        @(negedge clk_i);
        chk("arb_ar_ready", 64'(axi.ar_ready), 64'd1);
        chk("arb_aw_ready", 64'(axi.aw_ready), 64'd0);
        for (int k = 0; k < 50 && !axi.r_valid; k++) @(negedge clk_i);
        if (!axi.r_valid) timeout("r_valid");
        for (int k = 0; k < 5; k++) begin
          chk("hold_r_valid", 64'(axi.r_valid), 64'd1);
          chk("hold_r_data", axi.r_bits.data, 64'hDEADBEEF_01234567);
          chk("hold_r_id", 64'(axi.r_bits.id), 64'd1);
          @(negedge clk_i);
        end
        @(posedge clk_i); #1;
        axi.r_ready = 1'b1;
        for (int k = 0; k < 50 && !axi.b_valid; k++) @(negedge clk_i);
        if (!axi.b_valid) timeout("b_valid");
        for (int k = 0; k < 5; k++) begin
          chk("hold_b_valid", 64'(axi.b_valid), 64'd1);
          chk("hold_b_id", 64'(axi.b_bits.id), 64'd2);
          chk("hold_b_resp", 64'(axi.b_bits.resp), 64'(RESP_OKAY));
          @(negedge clk_i);
        end
        @(posedge clk_i); #1;
        axi.b_ready = 1'b1;
      end
    join
    drain("arbitration");

    // out-of-range read: DECERR, no SRAM access
    exp_r(4'd3, 64'd0, RESP_DECERR, 1'b0);
    exp_r(4'd3, 64'd0, RESP_DECERR, 1'b1);
    send_ar(4'd3, 32'h10000, 8'd1, 3'd3, BURST_INCR);
    drain("decerr_read");

    // early w.last: beats still written, SLVERR reported
    exp_wr(96, 64'h11, 8'hFF);
    exp_wr(97, 64'h22, 8'hF0);
    exp_b(4'd4, RESP_SLVERR);
    send_aw(4'd4, 32'h300, 8'd1, 3'd3, BURST_INCR);
    send_w(64'h11, 8'hFF, 1'b1);
    send_w(64'h22, 8'hF0, 1'b0);
    drain("slverr_write");

    // reset during beat 2 of an 8-beat write, then a clean read
    exp_wr(128, 64'h55, 8'hFF);
    exp_wr(129, 64'h66, 8'hFF);
    send_aw(4'd6, 32'h400, 8'd7, 3'd3, BURST_INCR);
    send_w(64'h55, 8'hFF, 1'b0);
    send_w(64'h66, 8'hFF, 1'b0);
    axi.w_bits.data = 64'h77;
    axi.w_valid = 1'b1;
    rst_i = 1'b0;
    #1;
    chk_idle_outputs("midburst_rst");
    axi.w_valid = 1'b0;
    repeat (2) @(posedge clk_i);
    #1;
    rst_i = 1'b1;
    chk("mem_untouched", mem[130], 64'bx);
    exp_rd(32);
    exp_r(4'd7, 64'd1, RESP_OKAY, 1'b1);
    send_ar(4'd7, 32'h100, 8'd0, 3'd3, BURST_INCR);
    drain("post_reset_read");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
